// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: bit-serial two's-complement adder/subtractor.
// Operands are loaded on a start pulse and pushed LSB-first through a single
// full-adder cell, one bit per clock. Each result bit is also streamed out.
// The parallel result and the carry/overflow flags update only on completion.
module serial_addsub_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             bit_out,
    output logic             bit_valid
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_cmsb;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_carry_nxt;
    logic             w_cmsb_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_cout_nxt;
    logic             w_ovf_nxt;
    logic             w_bit_out_nxt;
    logic             w_bit_valid_nxt;

    logic [1:0]       w_fa;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_sh;
    logic             w_last;
    logic             w_msb_m1;

    // Single full-adder cell and the result shift toward the LSB.
    assign w_fa     = {1'b0, r_a[0]} + {1'b0, r_b[0]} + {1'b0, r_carry};
    assign w_s      = w_fa[0];
    assign w_c      = w_fa[1];
    assign w_res_sh = {w_s, r_res[WIDTH-1:1]};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_msb_m1 = (r_cnt == CW'(WIDTH - 2));

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value logic for the datapath and outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_res_nxt       = r_res;
        w_carry_nxt     = r_carry;
        w_cmsb_nxt      = r_cmsb;
        w_cnt_nxt       = r_cnt;
        w_busy_nxt      = busy;
        w_done_nxt      = done;
        w_sum_nxt       = sum;
        w_cout_nxt      = cout;
        w_ovf_nxt       = ovf;
        w_bit_out_nxt   = bit_out;
        w_bit_valid_nxt = bit_valid;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry.
                    w_a_nxt     = a;
                    w_b_nxt     = sub ? ~b : b;
                    w_carry_nxt = sub;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_a_nxt         = {1'b0, r_a[WIDTH-1:1]};
                w_b_nxt         = {1'b0, r_b[WIDTH-1:1]};
                w_res_nxt       = w_res_sh;
                w_carry_nxt     = w_c;
                w_cnt_nxt       = r_cnt + CW'(1);
                w_bit_out_nxt   = w_s;
                w_bit_valid_nxt = 1'b1;
                if (w_msb_m1) begin
                    w_cmsb_nxt = w_c;
                end
                if (w_last) begin
                    w_sum_nxt   = w_res_sh;
                    w_cout_nxt  = w_c;
                    w_ovf_nxt   = r_cmsb ^ w_c;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done_nxt      = 1'b0;
                w_bit_valid_nxt = 1'b0;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cmsb    <= 1'b0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_res     <= w_res_nxt;
            r_carry   <= w_carry_nxt;
            r_cmsb    <= w_cmsb_nxt;
            r_cnt     <= w_cnt_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            sum       <= w_sum_nxt;
            cout      <= w_cout_nxt;
            ovf       <= w_ovf_nxt;
            bit_out   <= w_bit_out_nxt;
            bit_valid <= w_bit_valid_nxt;
        end
    end

endmodule
